// File: rtl/bcd_conv_arbiter_if.sv
// Handshake bundle for bcd_conv_arbiter: two requester channels carrying
// 8-bit binary values in, one result channel carrying 3-digit BCD out.
// The slave modport is the converter's view; master is the environment's.
interface bcd_conv_arbiter_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic [11:0] out_bcd;
  logic        out_id;
  logic        out_ready;

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    output out_valid,
    output out_bcd,
    output out_id,
    input  out_ready
  );

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    input  out_valid,
    input  out_bcd,
    input  out_id,
    output out_ready
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin arbiter in front of a sequential double-dabble
// binary-to-BCD converter. One 8-bit value is accepted from either requester,
// converted over several cycles and presented as three BCD digits together
// with the index of the requester that supplied it.
//
// Build option: define BCD_CONV_DUAL_SHIFT_EN to retire two add-3/shift
// iterations per cycle (4-cycle conversion instead of 8). Results are
// bit-identical in both builds.
module bcd_conv_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  bcd_conv_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    RESULT  = 2'd2
  } state_t;

`ifdef BCD_CONV_DUAL_SHIFT_EN
  // Two iterations per cycle: counter walks 0..3.
  localparam logic [2:0] LAST_CNT = 3'd3;
`else
  // One iteration per cycle: counter walks 0..7.
  localparam logic [2:0] LAST_CNT = 3'd7;
`endif

  // One double-dabble iteration: bump every digit >= 5 by 3, then shift the
  // {bcd, binary} pair left so the binary MSB enters the ones digit. For an
  // 8-bit source the hundreds digit never exceeds 2, so the bit shifted out
  // of the top is always zero.
  function automatic logic [19:0] dabble_step(input logic [11:0] bcd,
                                              input logic [7:0]  bin);
    logic [11:0] adj;
    adj = bcd;
    for (int d = 0; d < 3; d++) begin
      if (adj[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
      end
    end
    return {adj[10:0], bin, 1'b0};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_id;
  logic        r_ptr;

  logic [11:0] r_out_bcd;
  logic        r_out_id;
  logic        r_out_valid;

  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic        w_accept;
  logic        w_done;
  logic        w_out_hs;
  logic [7:0]  w_sel_data;
  logic [19:0] w_step1;
  logic [19:0] w_step;

  assign w_step1 = dabble_step(r_bcd, r_bin);

`ifdef BCD_CONV_DUAL_SHIFT_EN
  assign w_step = dabble_step(w_step1[19:8], w_step1[7:0]);
`else
  assign w_step = w_step1;
`endif

  // Grant decision: only in IDLE and out of reset; contention resolved by
  // the round-robin pointer, a lone requester always wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (rst_n && (r_state == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_ptr;
      end else if (bus.req0_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = 1'b1;
      end
    end
  end

  // A grant is only issued to a requester that is already valid, so a grant
  // is an accept.
  assign w_accept   = w_gnt_vld;
  assign w_sel_data = w_gnt_id ? bus.req1_data : bus.req0_data;
  assign w_done     = (r_state == CONVERT) && (r_cnt == LAST_CNT);
  assign w_out_hs   = r_out_valid && bus.out_ready;

  assign bus.req0_ready = w_gnt_vld & ~w_gnt_id;
  assign bus.req1_ready = w_gnt_vld &  w_gnt_id;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_bcd    = r_out_bcd;
  assign bus.out_id     = r_out_id;

  // Next-state logic for the IDLE -> CONVERT -> RESULT loop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = CONVERT;
        end
      end
      CONVERT: begin
        if (w_done) begin
          w_state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (w_out_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control: iteration counter, round-robin pointer and the result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 3'd0;
      r_ptr       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= 12'd0;
      r_out_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= 3'd0;
        r_ptr <= ~w_gnt_id;
      end else if (w_done) begin
        r_cnt <= 3'd0;
      end else if (r_state == CONVERT) begin
        r_cnt <= r_cnt + 3'd1;
      end

      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_bcd   <= w_step[19:8];
        r_out_id    <= r_id;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Datapath: capture on accept, then one (or two) dabble steps per cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bin <= w_sel_data;
      r_bcd <= 12'd0;
      r_id  <= w_gnt_id;
    end else if (r_state == CONVERT) begin
      r_bcd <= w_step[19:8];
      r_bin <= w_step[7:0];
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed testbench for bcd_conv_arbiter with a result scoreboard.
module tb_bcd_conv_arbiter;

`ifdef BCD_CONV_DUAL_SHIFT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  typedef struct {
    logic        id;
    logic [11:0] bcd;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  exp_t cur;
  bit   have;

  bcd_conv_arbiter_if iface ();

  bcd_conv_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (iface)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit id, input bit v, input logic [7:0] d);
    if (id) begin
      iface.req1_valid = v;
      iface.req1_data  = d;
    end else begin
      iface.req0_valid = v;
      iface.req0_data  = d;
    end
  endtask

  // Poll until requester 'id' is granted; the other ready must be low then.
  task automatic wait_grant(input bit id, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (id ? iface.req1_ready : iface.req0_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_grant"}, 32'(ok), 32'd1);
    chk({tag, "_other_ready"}, 32'(id ? iface.req0_ready : iface.req1_ready), 32'd0);
  endtask

  // Let the accept edge happen; optionally record the expected result.
  task automatic do_accept(input bit id, input int d, input bit push);
    exp_t e;
    if (push) begin
      e.id  = id;
      e.bcd = to_bcd(d);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0, 8'(d));
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !iface.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_drain"}, 32'(ok), 32'd1);
  endtask

  // Scoreboard monitor: pops the expectation when a result first appears,
  // then checks latency, value, id, hold and blocked readys each cycle.
  always @(negedge clk) begin
    if (iface.out_valid) begin
      if (!have) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 32'(iface.out_valid), 32'd0);
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
          chk("latency", 32'(cyc - cur.acc), 32'(LAT));
        end
      end
      if (have) begin
        chk("out_bcd", 32'(iface.out_bcd), 32'(cur.bcd));
        chk("out_id", 32'(iface.out_id), 32'(cur.id));
      end
      chk("ready_in_result", 32'({iface.req0_ready, iface.req1_ready}), 32'd0);
      if (iface.out_ready) have = 1'b0;
    end else begin
      have = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    have     = 1'b0;
    rst_n    = 1'b0;
    iface.out_ready = 1'b1;
    // Both requesters valid while in reset.
    set_req(1'b0, 1'b1, 8'd45);
    set_req(1'b1, 1'b1, 8'd128);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", 32'(iface.req0_ready), 32'd0);
    chk("rst_ready1", 32'(iface.req1_ready), 32'd0);
    chk("rst_out_valid", 32'(iface.out_valid), 32'd0);
    chk("rst_out_bcd", 32'(iface.out_bcd), 32'd0);
    chk("rst_out_id", 32'(iface.out_id), 32'd0);
    rst_n = 1'b1;

    // Contention at reset exit: req0 first, then req1.
    wait_grant(1'b0, "c45");
    do_accept(1'b0, 45, 1'b1);
    wait_grant(1'b1, "c128");
    do_accept(1'b1, 128, 1'b1);
    // Repeated contention alternates.
    set_req(1'b0, 1'b1, 8'd7);
    set_req(1'b1, 1'b1, 8'd200);
    wait_grant(1'b0, "c7");
    do_accept(1'b0, 7, 1'b1);
    set_req(1'b0, 1'b1, 8'd8);
    wait_grant(1'b1, "c200");
    do_accept(1'b1, 200, 1'b1);
    wait_grant(1'b0, "c8");
    do_accept(1'b0, 8, 1'b1);
    drain("contention");

    // req0 only.
    set_req(1'b0, 1'b1, 8'd0);
    wait_grant(1'b0, "r0_0");
    do_accept(1'b0, 0, 1'b1);
    set_req(1'b0, 1'b1, 8'd202);
    wait_grant(1'b0, "r0_202");
    do_accept(1'b0, 202, 1'b1);
    drain("req0");

    // req1 only.
    set_req(1'b1, 1'b1, 8'd255);
    wait_grant(1'b1, "r1_255");
    do_accept(1'b1, 255, 1'b1);
    set_req(1'b1, 1'b1, 8'd99);
    wait_grant(1'b1, "r1_99");
    do_accept(1'b1, 99, 1'b1);
    drain("req1");

    // Back-pressure: result held while out_ready is low.
    iface.out_ready = 1'b0;
    set_req(1'b0, 1'b1, 8'd13);
    wait_grant(1'b0, "bp13");
    do_accept(1'b0, 13, 1'b1);
    set_req(1'b1, 1'b1, 8'd50);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        #1;
        if (iface.out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("bp_out_valid_rise", 32'(seen), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(iface.out_valid), 32'd1);
      chk("bp_hold_bcd", 32'(iface.out_bcd), 32'h013);
      chk("bp_ready1_low", 32'(iface.req1_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    iface.out_ready = 1'b1;
    wait_grant(1'b1, "bp50");
    do_accept(1'b1, 50, 1'b1);
    drain("bp");

    // Reset during CONVERT iteration 4: no result may appear.
    set_req(1'b0, 1'b1, 8'd99);
    wait_grant(1'b0, "ab99");
    do_accept(1'b0, 99, 1'b0);
    repeat (LAT / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ab_out_valid", 32'(iface.out_valid), 32'd0);
    chk("ab_out_bcd", 32'(iface.out_bcd), 32'd0);
    chk("ab_out_id", 32'(iface.out_id), 32'd0);
    chk("ab_ready0", 32'(iface.req0_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      chk("ab_no_result", 32'(iface.out_valid), 32'd0);
    end
    // Pointer was reset to requester 0.
    set_req(1'b0, 1'b1, 8'd1);
    set_req(1'b1, 1'b1, 8'd2);
    wait_grant(1'b0, "ptr_rst");
    do_accept(1'b0, 1, 1'b1);
    wait_grant(1'b1, "ptr_next");
    do_accept(1'b1, 2, 1'b1);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 The block SHALL have parameter-free ports, listed below; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has a binary value to convert.
REQ-005 req0_data  input  8  requester 0 binary value (unsigned, 0..255).
REQ-006 req0_ready  output  1  requester 0 value accepted this cycle when high with req0_valid.
REQ-007 req1_valid  input  1  requester 1 has a binary value to convert.
REQ-008 req1_data  input  8  requester 1 binary value (unsigned, 0..255).
REQ-009 req1_ready  output  1  requester 1 value accepted this cycle when high with req1_valid.
REQ-010 out_valid  output  1  result available.
REQ-011 out_bcd  output  12  result: [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-012 out_id  output  1  index of the requester that owns the result.
REQ-013 out_ready  input  1  consumer accepts the result when high with out_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CONVERT, RESULT.
REQ-015 In IDLE, grant: one valid requester -> that one; both valid -> the requester named by the priority pointer; neither -> no grant.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted requester (combinational from state, valids and pointer); it SHALL be low in CONVERT and RESULT.
REQ-017 On an accept edge the block SHALL capture the data and requester index, clear the 12-bit BCD accumulator, load the iteration counter with 0, and enter CONVERT.
REQ-018 CONVERT SHALL perform one double-dabble iteration per cycle: add 3 to each BCD digit >= 5, then shift {bcd, binary} left by 1, MSB of binary first.
REQ-019 After 8 iterations (counter reaching 7) the block SHALL register the accumulator into out_bcd, the captured index into out_id, and enter RESULT.
REQ-020 out_valid SHALL rise exactly 8 clock edges after the accept edge and stay high with out_bcd/out_id stable until out_valid && out_ready.
REQ-021 On out_valid && out_ready the block SHALL return to IDLE next edge and drop out_valid; no new accept SHALL occur in that same cycle (minimum 10 cycles per conversion).
REQ-022 After each accept, the priority pointer SHALL point to the other requester (round-robin); it SHALL change only on accept.
REQ-023 out_bcd SHALL hold its last value when out_valid is low; each digit SHALL always be 0..9; 255 SHALL produce 0x255.
REQ-024 Requesters SHALL hold valid and data stable until accepted; a valid deasserted before accept SHALL be ignored without error.

Reset
REQ-025 While rst_n is low at a clock edge, the block SHALL enter IDLE with out_valid=0, out_bcd=0, out_id=0, counter=0, pointer=requester 0.
REQ-026 Reset asserted in CONVERT or RESULT SHALL abort the conversion; the partial result SHALL never appear on out_valid.
REQ-027 req0_ready/req1_ready SHALL be low while rst_n is low.

Configuration
REQ-028 Macro BCD_CONV_DUAL_SHIFT_EN defined: CONVERT SHALL perform two add-3/shift iterations per cycle, finishing in 4 cycles; out_valid SHALL rise 4 edges after accept.
REQ-029 Macro BCD_CONV_DUAL_SHIFT_EN undefined: one iteration per cycle, 8-cycle latency as in REQ-020; results SHALL be bit-identical in both builds.

Verification
REQ-030 req0 only, data 0 then 202, out_ready=1 -> out_bcd 0x000 then 0x202, out_id=0, out_valid 8 edges after each accept.
REQ-031 req1 only, data 255 and 99 -> out_bcd 0x255 and 0x099, out_id=1.
REQ-032 Both valid at reset exit, req0=45, req1=128 -> req0 accepted first (0x045, id 0), then req1 (0x128, id 1); repeated contention alternates.
REQ-033 out_ready low for 5 cycles in RESULT with data 13 -> out_valid and out_bcd=0x013 held, both readys low, accept only after handshake.
REQ-034 rst_n low for one edge at CONVERT iteration 4 with data 99 -> next cycle IDLE, out_valid=0, out_bcd=0, no result emitted.
REQ-035 With BCD_CONV_DUAL_SHIFT_EN, data 202 -> out_bcd 0x202 with out_valid 4 edges after accept.
